// File: rtl/esc_pwm_mixer.sv
// Quad-X motor mixer driving four ESC pulses. Commands are clamped into shadow registers
// and promoted to pulse widths only at frame boundaries. Motors are held at MIN_US when disarmed or stale.
module esc_pwm_mixer #(
   parameter int CLK_HZ         = 50_000_000,
   parameter int FRAME_US       = 2500,
   parameter int MIN_US         = 1000,
   parameter int RANGE          = 1000,
   parameter int TIMEOUT_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [11:0] throttle,
   input  logic [12:0] roll,
   input  logic [12:0] pitch,
   input  logic [12:0] yaw,
   input  logic        armed,
   output logic [3:0]  pwm_out,
   output logic        frame_sync,
   output logic        cmd_stale
);
   localparam int DIV = CLK_HZ / 1_000_000;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int UW  = $clog2(FRAME_US);
   localparam int RW  = $clog2(RANGE + 1);
   localparam int SW  = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic signed [16:0] RANGE_S = 17'(RANGE);

   logic [PW-1:0]        pre_q, pre_d;
   logic [UW-1:0]        us_cnt_q, us_cnt_d;
   logic [3:0][RW-1:0]   shadow_q, shadow_d, mix_c;
   logic [3:0][UW-1:0]   width_q, width_d;
   logic [SW-1:0]        stale_cnt_q, stale_cnt_d, stale_inc;
   logic                 cmd_stale_q, cmd_stale_d;
   logic                 frame_sync_q, frame_sync_d;
   logic [3:0]           pwm_q, pwm_d;
   logic                 tick, boundary;
   logic signed [16:0]   t_s, r_s, p_s, y_s, m0, m1, m2, m3;

   function automatic logic [RW-1:0] clamp(input logic signed [16:0] m);
      if (m[16])
         return '0;
      else if (m > RANGE_S)
         return RW'(RANGE);
      else
         return m[RW-1:0];
   endfunction

   // 17 bits holds T +/- 3 * 4096 at every input extreme, so no wrap before clamping.
   assign t_s = {5'b0, throttle};
   assign r_s = {{4{roll[12]}}, roll};
   assign p_s = {{4{pitch[12]}}, pitch};
   assign y_s = {{4{yaw[12]}}, yaw};
   assign m0  = t_s + p_s - r_s - y_s;
   assign m1  = t_s + p_s + r_s + y_s;
   assign m2  = t_s - p_s + r_s - y_s;
   assign m3  = t_s - p_s - r_s + y_s;

   always_comb begin
      mix_c[0] = clamp(m0);
      mix_c[1] = clamp(m1);
      mix_c[2] = clamp(m2);
      mix_c[3] = clamp(m3);

      tick     = (pre_q == PW'(DIV - 1));
      boundary = tick && (us_cnt_q == UW'(FRAME_US - 1));
      pre_d    = tick ? '0 : pre_q + 1'b1;
      us_cnt_d = us_cnt_q;
      if (tick)
         us_cnt_d = boundary ? '0 : us_cnt_q + 1'b1;
      frame_sync_d = boundary;

      stale_inc   = (stale_cnt_q == SW'(TIMEOUT_FRAMES)) ? stale_cnt_q : stale_cnt_q + 1'b1;
      stale_cnt_d = stale_cnt_q;
      cmd_stale_d = cmd_stale_q;
      if (cmd_valid) begin
         stale_cnt_d = '0;
         cmd_stale_d = 1'b0;
      end else if (boundary) begin
         stale_cnt_d = stale_inc;
         cmd_stale_d = (stale_inc == SW'(TIMEOUT_FRAMES));
      end

      shadow_d = cmd_valid ? mix_c : shadow_q;

      // Widths latch the pre-strobe shadow, so a command on the boundary waits one frame.
      width_d = width_q;
      for (int i = 0; i < 4; i++) begin
         if (boundary)
            width_d[i] = (armed && !cmd_stale_d) ? UW'(MIN_US) + UW'(shadow_q[i]) : UW'(MIN_US);
         pwm_d[i] = (us_cnt_q < width_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q        <= '0;
         us_cnt_q     <= '0;
         shadow_q     <= '0;
         width_q      <= {4{UW'(MIN_US)}};
         stale_cnt_q  <= SW'(TIMEOUT_FRAMES);
         cmd_stale_q  <= 1'b1;
         frame_sync_q <= 1'b0;
         pwm_q        <= '0;
      end else begin
         pre_q        <= pre_d;
         us_cnt_q     <= us_cnt_d;
         shadow_q     <= shadow_d;
         width_q      <= width_d;
         stale_cnt_q  <= stale_cnt_d;
         cmd_stale_q  <= cmd_stale_d;
         frame_sync_q <= frame_sync_d;
         pwm_q        <= pwm_d;
      end
   end

   assign pwm_out    = pwm_q;
   assign frame_sync = frame_sync_q;
   assign cmd_stale  = cmd_stale_q;
endmodule

// File: tb/tb_esc_pwm_mixer.sv
// Directed bench for esc_pwm_mixer on a scaled timebase: 2 clocks per us, 250 us frame,
// 100..200 us pulses, so every expected width below is the spec value divided by ten.
module tb_esc_pwm_mixer;
   localparam int DIV = 2;
   localparam int FC  = 250 * DIV;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, armed;
   logic [11:0] throttle;
   logic [12:0] roll, pitch, yaw;
   logic [3:0]  pwm_out;
   logic        frame_sync, cmd_stale;

   int checks = 0;
   int errors = 0;
   int hi_cnt[4];
   int sync_seen;
   logic last_sync;

   esc_pwm_mixer #(
      .CLK_HZ(2_000_000), .FRAME_US(250), .MIN_US(100), .RANGE(100), .TIMEOUT_FRAMES(8)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .throttle(throttle), .roll(roll),
      .pitch(pitch), .yaw(yaw), .armed(armed), .pwm_out(pwm_out),
      .frame_sync(frame_sync), .cmd_stale(cmd_stale)
   );

   always #5 clk = ~clk;

   // Counts high samples per motor over one frame; optionally changes armed at sample ev_cyc.
   task automatic measure(input bit wait_sync, input int ev_cyc, input logic ev_arm);
      int n;
      n = 0;
      if (wait_sync) begin
         while (frame_sync !== 1'b1 && n < 2 * FC) begin
            @(negedge clk);
            n++;
         end
         if (frame_sync !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL sync_timeout frame_sync got %b exp 1 within %0d cycles", frame_sync, 2 * FC);
         end
      end
      for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
      sync_seen = 0;
      for (int k = 1; k <= FC; k++) begin
         if (k == ev_cyc) armed = ev_arm;
         @(negedge clk);
         for (int i = 0; i < 4; i++) if (pwm_out[i] === 1'b1) hi_cnt[i]++;
         if (frame_sync === 1'b1) sync_seen++;
      end
      last_sync = frame_sync;
   endtask

   task automatic send_cmd(input int t, input int r, input int p, input int y);
      throttle  = 12'(t);
      roll      = 13'(r);
      pitch     = 13'(p);
      yaw       = 13'(y);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; armed = 1'b0;
      throttle = '0; roll = '0; pitch = '0; yaw = '0;
      repeat (3) @(negedge clk);
      checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL reset_pwm got %h exp 0", pwm_out); end
      checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got %b exp 0", frame_sync); end
      checks++; if (cmd_stale !== 1'b1) begin errors++; $display("FAIL reset_stale got %b exp 1", cmd_stale); end
      rst = 1'b0;
      for (int f = 0; f < 2; f++) begin
         measure(f != 0, 0, 1'b0);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== 100 * DIV) begin
               errors++; $display("FAIL disarmed_width f%0d m%0d got %0d exp %0d", f, i, hi_cnt[i], 100 * DIV);
            end
         end
         checks++;
         if (sync_seen !== 1 || last_sync !== 1'b1) begin
            errors++; $display("FAIL frame_period f%0d syncs %0d last %b exp 1 1", f, sync_seen, last_sync);
         end
         checks++; if (cmd_stale !== 1'b1) begin errors++; $display("FAIL idle_stale got %b exp 1", cmd_stale); end
      end
   endtask

   task automatic test_basic;
      armed = 1'b1;
      checks++; if (cmd_stale !== 1'b1) begin errors++; $display("FAIL pre_cmd_stale got %b exp 1", cmd_stale); end
      send_cmd(50, 0, 0, 0);
      checks++; if (cmd_stale !== 1'b0) begin errors++; $display("FAIL stale_drop got %b exp 0", cmd_stale); end
      measure(1, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (hi_cnt[i] !== 150 * DIV) begin
            errors++; $display("FAIL basic_width m%0d got %0d exp %0d", i, hi_cnt[i], 150 * DIV);
         end
      end
   endtask

   task automatic test_clamp;
      int cmd[4][4];
      int exp_us[4][4];
      cmd[0] = '{90, 0, 20, 0};            exp_us[0] = '{200, 200, 170, 170};
      cmd[1] = '{5, -30, 0, 0};            exp_us[1] = '{135, 100, 100, 135};
      cmd[2] = '{4095, 4095, 4095, 4095};  exp_us[2] = '{100, 200, 100, 100};
      cmd[3] = '{0, -4096, -4096, -4096};  exp_us[3] = '{200, 100, 200, 200};
      for (int v = 0; v < 4; v++) begin
         send_cmd(cmd[v][0], cmd[v][1], cmd[v][2], cmd[v][3]);
         measure(1, 0, 1'b0);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_us[v][i] * DIV) begin
               errors++; $display("FAIL clamp_width v%0d m%0d got %0d exp %0d", v, i, hi_cnt[i], exp_us[v][i] * DIV);
            end
         end
      end
   endtask

   task automatic test_stale;
      int ew;
      send_cmd(40, 0, 0, 0);
      for (int f = 1; f <= 8; f++) begin
         measure(1, 0, 1'b0);
         ew = (f < 8) ? 140 : 100;
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== ew * DIV) begin
               errors++; $display("FAIL stale_width f%0d m%0d got %0d exp %0d", f, i, hi_cnt[i], ew * DIV);
            end
         end
         checks++;
         if (cmd_stale !== ((f + 1 >= 8) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL stale_flag after f%0d got %b exp %b", f, cmd_stale, (f + 1 >= 8));
         end
      end
      send_cmd(40, 0, 0, 0);
      checks++; if (cmd_stale !== 1'b0) begin errors++; $display("FAIL stale_clear got %b exp 0", cmd_stale); end
      measure(1, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (hi_cnt[i] !== 140 * DIV) begin
            errors++; $display("FAIL stale_recover m%0d got %0d exp %0d", i, hi_cnt[i], 140 * DIV);
         end
      end
   endtask

   task automatic test_disarm;
      int ew[3];
      int ev_cyc[3];
      logic ev_val[3];
      ew = '{150, 100, 150};
      ev_cyc = '{120 * DIV + 1, 50 * DIV + 1, 0};
      ev_val = '{1'b0, 1'b1, 1'b1};
      send_cmd(50, 0, 0, 0);
      measure(1, 0, 1'b0);
      for (int f = 0; f < 3; f++) begin
         measure(1, ev_cyc[f], ev_val[f]);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== ew[f] * DIV) begin
               errors++; $display("FAIL disarm_width f%0d m%0d got %0d exp %0d", f, i, hi_cnt[i], ew[f] * DIV);
            end
         end
      end
   endtask

   task automatic test_boundary_cmd;
      repeat (FC - 1) @(negedge clk);
      throttle = 12'd70; roll = '0; pitch = '0; yaw = '0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (frame_sync !== 1'b1) begin errors++; $display("FAIL bnd_align frame_sync got %b exp 1", frame_sync); end
      checks++; if (cmd_stale !== 1'b0) begin errors++; $display("FAIL bnd_stale got %b exp 0", cmd_stale); end
      for (int f = 0; f < 2; f++) begin
         measure(1, 0, 1'b0);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== ((f == 0) ? 150 : 170) * DIV) begin
               errors++; $display("FAIL bnd_width f%0d m%0d got %0d exp %0d", f, i, hi_cnt[i], ((f == 0) ? 150 : 170) * DIV);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      repeat (80 * DIV) @(negedge clk);
      checks++; if (pwm_out !== 4'hF) begin errors++; $display("FAIL mid_pulse got %h exp f", pwm_out); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL rst_pwm got %h exp 0", pwm_out); end
      checks++; if (cmd_stale !== 1'b1) begin errors++; $display("FAIL rst_stale got %b exp 1", cmd_stale); end
      @(negedge clk);
      rst = 1'b0;
      measure(0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (hi_cnt[i] !== 100 * DIV) begin
            errors++; $display("FAIL restart_width m%0d got %0d exp %0d", i, hi_cnt[i], 100 * DIV);
         end
      end
      checks++;
      if (sync_seen !== 1 || last_sync !== 1'b1) begin
         errors++; $display("FAIL restart_period syncs %0d last %b exp 1 1", sync_seen, last_sync);
      end
      send_cmd(70, 0, 0, 0);
      measure(1, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (hi_cnt[i] !== 170 * DIV) begin
            errors++; $display("FAIL restart_cmd m%0d got %0d exp %0d", i, hi_cnt[i], 170 * DIV);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_clamp;
      test_stale;
      test_disarm;
      test_boundary_cmd;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
